// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - two-port round-robin memory arbiter (fixed priority with ARBITER_FIXED_PRIO_EN)
module memory_arbiter #(
  parameter int MEMORY_SIZE = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_write,
  input  logic [1:0]  p0_option,
  input  logic [31:0] p0_address,
  input  logic [31:0] p0_write_data,
  input  logic        p1_req,
  input  logic        p1_write,
  input  logic [1:0]  p1_option,
  input  logic [31:0] p1_address,
  input  logic [31:0] p1_write_data,
  output logic        p0_ack,
  output logic        p0_err,
  output logic [31:0] p0_read_data,
  output logic        p1_ack,
  output logic        p1_err,
  output logic [31:0] p1_read_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_option,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  // Word-granular bound: only address[31:2] decides whether the access is in range.
  localparam logic [29:0] LP_WORDS = 30'(MEMORY_SIZE / 4);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_last_grant;
  logic        r_grant;
  logic        r_err;
  logic        r_busy;
  logic        r_mem_read;
  logic        r_mem_write;
  logic [1:0]  r_mem_option;
  logic [31:0] r_mem_address;
  logic [31:0] r_mem_write_data;
  logic        r_p0_ack;
  logic        r_p0_err;
  logic [31:0] r_p0_read_data;
  logic        r_p1_ack;
  logic        r_p1_err;
  logic [31:0] r_p1_read_data;

  logic        w_any_req;
  logic        w_winner;
  logic        w_sel_write;
  logic [1:0]  w_sel_option;
  logic [31:0] w_sel_address;
  logic [31:0] w_sel_write_data;
  logic        w_in_range;

  // Choose the winning port and mux its command fields.
  always_comb begin
    w_any_req = p0_req | p1_req;
`ifdef ARBITER_FIXED_PRIO_EN
    w_winner = p1_req;
`else
    w_winner = (p0_req && p1_req) ? ~r_last_grant : p1_req;
`endif
    w_sel_write      = w_winner ? p1_write      : p0_write;
    w_sel_option     = w_winner ? p1_option     : p0_option;
    w_sel_address    = w_winner ? p1_address    : p0_address;
    w_sel_write_data = w_winner ? p1_write_data : p0_write_data;
    w_in_range       = (w_sel_address[31:2] < LP_WORDS);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic: each state lasts exactly one cycle once a request is taken.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:   if (w_any_req) w_next_state = S_ACCESS;
      S_ACCESS: w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Registered datapath: memory controls, captured read data, ack/err pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant     <= 1'b1;
      r_grant          <= 1'b0;
      r_err            <= 1'b0;
      r_busy           <= 1'b0;
      r_mem_read       <= 1'b0;
      r_mem_write      <= 1'b0;
      r_mem_option     <= 2'b00;
      r_mem_address    <= 32'h0;
      r_mem_write_data <= 32'h0;
      r_p0_ack         <= 1'b0;
      r_p0_err         <= 1'b0;
      r_p0_read_data   <= 32'h0;
      r_p1_ack         <= 1'b0;
      r_p1_err         <= 1'b0;
      r_p1_read_data   <= 32'h0;
    end else begin
      r_busy <= (w_next_state != S_IDLE);
      unique case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_grant          <= w_winner;
            r_last_grant     <= w_winner;
            r_err            <= ~w_in_range;
            r_mem_read       <= w_in_range & ~w_sel_write;
            r_mem_write      <= w_in_range & w_sel_write;
            r_mem_option     <= w_in_range ? w_sel_option     : 2'b00;
            r_mem_address    <= w_in_range ? w_sel_address    : 32'h0;
            r_mem_write_data <= w_in_range ? w_sel_write_data : 32'h0;
          end
        end
        S_ACCESS: begin
          r_mem_read       <= 1'b0;
          r_mem_write      <= 1'b0;
          r_mem_option     <= 2'b00;
          r_mem_address    <= 32'h0;
          r_mem_write_data <= 32'h0;
          if (r_grant) begin
            r_p1_ack       <= 1'b1;
            r_p1_err       <= r_err;
            r_p1_read_data <= r_mem_read ? mem_read_data : 32'h0;
          end else begin
            r_p0_ack       <= 1'b1;
            r_p0_err       <= r_err;
            r_p0_read_data <= r_mem_read ? mem_read_data : 32'h0;
          end
        end
        S_DONE: begin
          r_p0_ack <= 1'b0;
          r_p0_err <= 1'b0;
          r_p1_ack <= 1'b0;
          r_p1_err <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign p0_ack         = r_p0_ack;
  assign p0_err         = r_p0_err;
  assign p0_read_data   = r_p0_read_data;
  assign p1_ack         = r_p1_ack;
  assign p1_err         = r_p1_err;
  assign p1_read_data   = r_p1_read_data;
  assign mem_read       = r_mem_read;
  assign mem_write      = r_mem_write;
  assign mem_option     = r_mem_option;
  assign mem_address    = r_mem_address;
  assign mem_write_data = r_mem_write_data;
  assign busy           = r_busy;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb/tb_memory_arbiter.sv - self-checking bench for memory_arbiter with byte-lane memory model
module tb_memory_arbiter;

  localparam int MEM_SIZE = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        p0_req, p0_write, p1_req, p1_write;
  logic [1:0]  p0_option, p1_option;
  logic [31:0] p0_address, p0_write_data, p1_address, p1_write_data;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic [31:0] p0_read_data, p1_read_data;
  logic        mem_read, mem_write, busy;
  logic [1:0]  mem_option;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  always #5 clk = ~clk;

  memory_arbiter #(.MEMORY_SIZE(MEM_SIZE)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_write(p0_write), .p0_option(p0_option),
    .p0_address(p0_address), .p0_write_data(p0_write_data),
    .p1_req(p1_req), .p1_write(p1_write), .p1_option(p1_option),
    .p1_address(p1_address), .p1_write_data(p1_write_data),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_read_data(p0_read_data),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_read_data(p1_read_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_option(mem_option),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .busy(busy)
  );

  // Little-endian byte memory, zero-extending sub-word reads.
  logic [7:0]  mem [0:MEM_SIZE-1];
  logic [11:0] ma;
  assign ma = mem_address[11:0];

  always_comb begin
    case (mem_option)
      2'b00:   mem_read_data = {24'h0, mem[ma]};
      2'b01:   mem_read_data = {16'h0, mem[ma + 12'd1], mem[ma]};
      default: mem_read_data = {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_write) begin
      mem[ma] <= mem_write_data[7:0];
      if (mem_option != 2'b00) mem[ma + 12'd1] <= mem_write_data[15:8];
      if (mem_option[1]) begin
        mem[ma + 12'd2] <= mem_write_data[23:16];
        mem[ma + 12'd3] <= mem_write_data[31:24];
      end
    end
  end

  typedef struct {
    logic        port;
    logic        write;
    logic [1:0]  option;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   ack_cyc[$];
  int   ack_port[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: every ack pops the oldest expectation for that port.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (p0_ack) begin
        ack_cyc.push_back(cyc);
        ack_port.push_back(0);
        if (q0.size() == 0) check("p0 unexpected ack", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          check("p0_read_data", p0_read_data, e.rdata);
          check("p0_err", {31'h0, p0_err}, {31'h0, e.err});
        end
      end
      if (p1_ack) begin
        ack_cyc.push_back(cyc);
        ack_port.push_back(1);
        if (q1.size() == 0) check("p1 unexpected ack", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          check("p1_read_data", p1_read_data, e.rdata);
          check("p1_err", {31'h0, p1_err}, {31'h0, e.err});
        end
      end
    end
  end

  // Issue one command starting at a negedge; returns at a negedge with the arbiter idle.
  task automatic issue(input vec_t v);
    int   lat;
    logic got;
    logic saw_mem;
    exp_t e;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    if (v.port) begin
      p1_req = 1'b1; p1_write = v.write; p1_option = v.option;
      p1_address = v.address; p1_write_data = v.wdata;
      q1.push_back(e);
    end else begin
      p0_req = 1'b1; p0_write = v.write; p0_option = v.option;
      p0_address = v.address; p0_write_data = v.wdata;
      q0.push_back(e);
    end
    lat = 0; got = 1'b0; saw_mem = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (mem_read || mem_write) saw_mem = 1'b1;
      if (v.port ? p1_ack : p0_ack) got = 1'b1;
    end
    check($sformatf("ack latency @%h", v.address), lat, 32'd2);
    if (v.exp_err) check($sformatf("mem enable on error @%h", v.address), {31'h0, saw_mem}, 32'd0);
    p0_req = 1'b0;
    p1_req = 1'b0;
    @(negedge clk);
  endtask

  vec_t vecs[11];
  int   c0;
  exp_t z;

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'h00;

    vecs[0]  = '{1'b1, 1'b1, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 2'b00, 32'h0000_0010, 32'h0,         32'h0000_00EF, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 2'b01, 32'h0000_0012, 32'h0,         32'h0000_DEAD, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 2'b10, 32'h0000_1000, 32'h0,         32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 2'b10, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 2'b11, 32'h0000_0FFC, 32'h0,         32'hCAFE_F00D, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 2'b10, 32'h0000_1000, 32'h1111_1111, 32'h0000_0000, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 2'b10, 32'hFFFF_FFFC, 32'h0,         32'h0000_0000, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 2'b00, 32'h0000_0021, 32'h0000_00AB, 32'h0000_0000, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 2'b10, 32'h0000_0020, 32'h0,         32'h0000_AB00, 1'b0};

    // Reset held with both requesters active: every output must stay at zero.
    reset = 1'b1;
    p0_req = 1'b1; p0_write = 1'b0; p0_option = 2'b10; p0_address = 32'h40; p0_write_data = 32'h0;
    p1_req = 1'b1; p1_write = 1'b0; p1_option = 2'b10; p1_address = 32'h44; p1_write_data = 32'h0;
    repeat (3) @(negedge clk);
    check("reset ctl outs", {23'h0, p0_ack, p1_ack, p0_err, p1_err, mem_read, mem_write, busy, mem_option}, 32'h0);
    check("reset p0_read_data", p0_read_data, 32'h0);
    check("reset p1_read_data", p1_read_data, 32'h0);
    check("reset mem_address", mem_address, 32'h0);
    check("reset mem_write_data", mem_write_data, 32'h0);

    // Both requesters held for 12 cycles after release: 4 grants, one every 3 cycles.
    z.rdata = 32'h0;
    z.err   = 1'b0;
`ifdef ARBITER_FIXED_PRIO_EN
    repeat (4) q1.push_back(z);
`else
    repeat (2) begin q0.push_back(z); q1.push_back(z); end
`endif
    reset = 1'b0;
    c0 = cyc;
    repeat (12) @(negedge clk);
    p0_req = 1'b0;
    p1_req = 1'b0;
    @(negedge clk);
    check("held-req ack count", ack_cyc.size(), 32'd4);
    for (int i = 0; i < 4 && i < ack_cyc.size(); i++) begin
      check($sformatf("held-req ack%0d cycle", i), ack_cyc[i] - c0, 2 + 3 * i);
`ifdef ARBITER_FIXED_PRIO_EN
      check($sformatf("held-req ack%0d port", i), ack_port[i], 32'd1);
`else
      check($sformatf("held-req ack%0d port", i), ack_port[i], i % 2);
`endif
    end

    // Table-driven single transactions.
    for (int i = 0; i < 11; i++) issue(vecs[i]);

    // Reset during ACCESS aborts the store: no write, no ack.
    p1_req = 1'b1; p1_write = 1'b1; p1_option = 2'b10;
    p1_address = 32'h20; p1_write_data = 32'h1234_5678;
    @(negedge clk);
    check("abort mem_write in ACCESS", {31'h0, mem_write}, 32'd1);
    check("abort busy in ACCESS", {31'h0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort mem_write after reset", {31'h0, mem_write}, 32'd0);
    check("abort busy after reset", {31'h0, busy}, 32'd0);
    p1_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    issue('{1'b1, 1'b0, 2'b10, 32'h0000_0020, 32'h0, 32'h0000_AB00, 1'b0});

    check("p0 scoreboard drained", q0.size(), 32'd0);
    check("p1 scoreboard drained", q1.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Two-port request/acknowledge arbiter that shares the single-ported data memory between the instruction-fetch port (port 0) and the load/store port (port 1).
- Owns every memory control input (read enable, write enable, size option, address, write data).
- Returns captured read data and an acknowledge to the winning requester.
- Sits between the core's fetch/LSU and the memory peripheral. Round-robin by default; fixed priority when the optional feature is compiled in.

Parameters:
- MEMORY_SIZE, 4096, memory size in bytes. Byte addresses >= MEMORY_SIZE are rejected with an error response.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- p0_req, p1_req  input  1  request; held high until the matching ack
- p0_write, p1_write  input  1  1=store, 0=load
- p0_option, p1_option  input  2  access size: 00 byte, 01 half, 10/11 word
- p0_address, p1_address  input  32  byte address
- p0_write_data, p1_write_data  input  32  store data
- p0_ack, p1_ack  output  1  one-cycle completion pulse
- p0_err, p1_err  output  1  out-of-range flag; valid only with ack
- p0_read_data, p1_read_data  output  32  load data; valid only with ack
- mem_read, mem_write  output  1  memory read/write enables
- mem_option  output  2  size to memory
- mem_address  output  32  address to memory
- mem_write_data  output  32  store data to memory
- mem_read_data  input  32  combinational read data from memory
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, immediate):
  - state=IDLE; last_grant=1, so port 0 wins the first tie.
  - All outputs 0: acks, errs, read_data, all mem_* signals, busy.
- All outputs are registered; nothing combinational from requester inputs to outputs.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE, one cycle each.
- IDLE: if any req is high at the clock edge:
  - pick the winner and latch its write, option, address and write_data;
  - set last_grant=winner; go to ACCESS.
  - If address < MEMORY_SIZE: mem_read=~write, mem_write=write, and mem_option/mem_address/mem_write_data are driven from the latched values.
  - Otherwise all mem_* stay 0 and an error flag is latched.
- ACCESS: memory sees stable controls for the whole cycle. At the edge:
  - memory performs the write;
  - the arbiter captures mem_read_data into the winner's read_data (0 for stores and for errors);
  - all mem_* clear to 0; winner's ack=1 and err=latched flag; go to DONE.
- DONE: ack/err held for exactly this one cycle. At the edge: ack and err clear, go to IDLE. read_data holds its value until the next ack to that port.
- Latency: req sampled at edge N, ack visible in cycle N+2. Minimum issue interval is 3 cycles. A requester may present a new command in the cycle after its ack.
- Arbitration (default round-robin):
  - only one requester high: it wins;
  - both high: the port that is not last_grant wins.
- Loser's req is ignored this round. It is reconsidered at the next IDLE; no request is dropped.
- A request whose req falls before grant is simply not served. Dropping req after grant is ignored; the transaction completes.
- Address bounds: only address[31:2] selects the word. Sub-word lanes are the memory's responsibility. Misalignment is not checked.
- Boundaries:
  - Address MEMORY_SIZE-4 is valid; address MEMORY_SIZE is an error.
  - An error never asserts mem_read or mem_write.
- Reset mid-transaction:
  - reset during ACCESS clears mem_write before the edge, so no write occurs;
  - a pending ack is lost; requesters must reissue.

Optional Feature:
- Macro ARBITER_FIXED_PRIO_EN.
- Defined: port 1 (load/store) always wins when both ports request; last_grant is still updated but not used.
- Undefined: round-robin as above.
- Latency, errors and all other behaviour are identical in both builds.

Test Plan:
- Reset with both reqs high -> all outputs 0 while reset is asserted. After release, port 0 is granted first; p0_ack is seen 2 cycles after the first sampling edge.
- p1 store: option=10, address=0x10, data=0xDEADBEEF. Then p1 load: option=10, address=0x10 -> p1_read_data=0xDEADBEEF, p1_err=0, each ack 2 cycles after its request.
- p0 load: option=00, address=0x10, after the word store above -> p0_read_data=0x000000EF.
- Both reqs held high for 12 cycles -> grants alternate p0,p1,p0,p1; exactly 4 acks, one every 3 cycles. With ARBITER_FIXED_PRIO_EN: all 4 acks go to p1.
- p0 load at address 0x1000 (MEMORY_SIZE=4096) -> p0_ack=1, p0_err=1, p0_read_data=0, mem_read never asserted. Address 0xFFC -> err=0.
- p1 store 0x12345678 to 0x20; assert reset during ACCESS; release; then load 0x20 -> the old value is returned and no ack is seen for the aborted store.
